room_driver: RTL and testbench
==============================

Name: room_driver

Overview:
- Command-side counterpart of the dungeon room state machine: converts four raw direction buttons into clean single-cycle n/s/e/w move pulses for the room FSM.
- Rate-limits moves so that only one move is issued per holdoff window.
- Maintains the sword-held flag v from the room's sw status.
- Freezes all moves once the room reports a win or a death.
- Sits between the board buttons and the room FSM; uses the same clock as the room FSM.

Parameters:
- DEBOUNCE_CYCLES, 4: number of consecutive identical synchronized samples required before a button level is accepted.
- GAP_CYCLES, 3: number of idle cycles enforced after each move pulse before the next pulse may be issued; legal range 1..255.
- CNT_W, 8: width of move_count.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- btn_n  in  1  raw north button, asynchronous to clk.
- btn_s  in  1  raw south button, asynchronous to clk.
- btn_e  in  1  raw east button, asynchronous to clk.
- btn_w  in  1  raw west button, asynchronous to clk.
- room_sw  in  1  room FSM is in the sword-stash room.
- room_win  in  1  room FSM is in the victory state.
- room_d  in  1  room FSM is in the dead state.
- n  out  1  one-cycle north move pulse to the room FSM.
- s  out  1  one-cycle south move pulse.
- e  out  1  one-cycle east move pulse.
- w  out  1  one-cycle west move pulse.
- v  out  1  sword held; sticky.
- busy  out  1  high in the PULSE and GAP states.
- game_over  out  1  high in the DONE state.
- move_count  out  CNT_W  number of pulses issued; saturating.

Behaviour:
- Reset (reset_n low, asynchronous assert): n=s=e=w=0, v=0, busy=0, game_over=0, move_count=0. Synchronizers, debounce state and the pending mask all clear; FSM goes to IDLE. Release is sampled on the next clk edge. Reset mid-pulse or mid-gap aborts immediately; no partial pulse is emitted.
- Input conditioning: each button passes through a 2-flop synchronizer, then the debounce stage, producing a debounced level. A 0->1 transition of the debounced level is an edge event. Holding a button produces exactly one edge.
- Pending mask: 4 bits, ordered {N,S,E,W}.
  - An edge event sets its bit.
  - Edges arriving while the bit is already set are merged (no counting).
- FSM states and transitions:
  - IDLE: if the pending mask is nonzero, select the highest-priority bit (N > S > E > W), clear that bit only, and go to PULSE.
  - PULSE: exactly one cycle. Only the selected direction output is high. move_count increments, saturating at 2^CNT_W-1. Next state is GAP with the gap counter loaded to GAP_CYCLES.
  - GAP: decrement the gap counter each cycle; on reaching 0 go to IDLE. New edges continue to accumulate in the pending mask.
  - DONE: entered from any state on the cycle after room_win or room_d is sampled high. The pending mask clears, no further pulses are issued, and game_over=1. The only exit is reset_n.
- Latency: with IDLE and an empty mask, an edge event produces its pulse 2 cycles later (mask set, then IDLE select, then PULSE). Minimum spacing between consecutive pulses is GAP_CYCLES+2 cycles.
- Simultaneous edges: all set their bits and are emitted one per window in priority order. A pulse never has more than one direction high.
- Win/death and pulse in the same cycle: a pulse in flight completes, then DONE takes priority over GAP/IDLE.
- v: set on the first clk where room_sw=1, then stays 1 until reset. v is independent of DONE.
- Output timing: all outputs are registered; no combinational path from inputs to outputs.

Optional Feature:
- ROOM_DRIVER_DEBOUNCE_EN defined: a per-button counter requires DEBOUNCE_CYCLES consecutive identical synchronized samples before the debounced level changes. Glitches shorter than that are ignored.
- Not defined: the debounced level equals the synchronized level. The DEBOUNCE_CYCLES parameter is ignored, and edge-to-pulse latency drops by DEBOUNCE_CYCLES cycles.

Test Plan:
- Reset, then btn_e held high for 20 cycles (debounce enabled, DEBOUNCE_CYCLES=4, GAP_CYCLES=3) -> exactly one e pulse of width 1, move_count=1, no other direction pulses.
- btn_n and btn_w rise in the same cycle -> n pulse, then w pulse exactly GAP_CYCLES+2=5 cycles later; move_count=2.
- btn_s glitch high for 2 cycles with debounce enabled -> no pulse, move_count=0. Same stimulus with the macro undefined -> one s pulse.
- room_sw pulsed high for 1 cycle, then low -> v=1 from the next cycle and remains 1 for 100 cycles; reset_n low -> v=0 immediately (asynchronous).
- room_d asserted while two moves are pending -> game_over=1 on the next cycle, pending moves are discarded, and further button presses produce no pulses until reset.
- Press-release sequences totalling 260 presses with CNT_W=8 -> move_count saturates at 255 and does not wrap.

Source files
------------

// File: rtl/room_driver.sv
`default_nettype none
// ----------------------------------------------------------------------------
// room_driver : button conditioner and rate-limited n/s/e/w pulser for the room FSM
// Option ROOM_DRIVER_DEBOUNCE_EN adds per-button debounce counters.   Rev 1.0
// ----------------------------------------------------------------------------
module room_driver #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int GAP_CYCLES      = 3,
  parameter int CNT_W           = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             btn_n,
  input  logic             btn_s,
  input  logic             btn_e,
  input  logic             btn_w,
  input  logic             room_sw,
  input  logic             room_win,
  input  logic             room_d,
  output logic             n,
  output logic             s,
  output logic             e,
  output logic             w,
  output logic             v,
  output logic             busy,
  output logic             game_over,
  output logic [CNT_W-1:0] move_count
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_PULSE = 2'd1,
    ST_GAP   = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  if (GAP_CYCLES < 1 || GAP_CYCLES > 255 || DEBOUNCE_CYCLES < 1) begin : g_param_check
    $error("room_driver: parameter out of range");
  end

  state_t           state_q, state_d;
  logic [3:0]       sync1_q, sync1_d, sync2_q, sync2_d;
  logic [3:0]       level, level_prev_q, level_prev_d, edge_evt, sel;
  logic [3:0]       mask_q, mask_d, dir_q, dir_d;
  logic [7:0]       gap_q, gap_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             v_q, v_d, busy_q, busy_d, over_q, over_d;

`ifdef ROOM_DRIVER_DEBOUNCE_EN
  localparam int DB_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);

  logic [DB_W-1:0] db_cnt_q [4];
  logic [DB_W-1:0] db_cnt_d [4];
  logic [3:0]      db_level_q, db_level_d;

  // Count consecutive samples that disagree with the accepted level; any agreeing sample restarts the run.
  always_comb begin
    db_level_d = db_level_q;
    for (int i = 0; i < 4; i++) begin
      db_cnt_d[i] = '0;
      if (sync2_q[i] != db_level_q[i]) begin
        if (db_cnt_q[i] == DB_LAST) db_level_d[i] = sync2_q[i];
        else                        db_cnt_d[i]   = db_cnt_q[i] + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      db_level_q <= '0;
      for (int i = 0; i < 4; i++) db_cnt_q[i] <= '0;
    end else begin
      db_level_q <= db_level_d;
      for (int i = 0; i < 4; i++) db_cnt_q[i] <= db_cnt_d[i];
    end
  end

  assign level = db_level_q;
`else
  assign level = sync2_q;
`endif

  always_comb begin
    sync1_d      = {btn_n, btn_s, btn_e, btn_w};
    sync2_d      = sync1_q;
    level_prev_d = level;
    edge_evt     = level & ~level_prev_q;

    if      (mask_q[3]) sel = 4'b1000;
    else if (mask_q[2]) sel = 4'b0100;
    else if (mask_q[1]) sel = 4'b0010;
    else                sel = 4'b0001;

    state_d = state_q;
    mask_d  = mask_q | edge_evt;
    dir_d   = '0;
    gap_d   = gap_q;
    count_d = count_q;
    v_d     = v_q | room_sw;

    // A pulse already on the outputs has completed; win/death overrides whatever follows it.
    if (state_q == ST_DONE || room_win || room_d) begin
      state_d = ST_DONE;
      mask_d  = '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (|mask_q) begin
            mask_d  = (mask_q & ~sel) | edge_evt;
            dir_d   = sel;
            state_d = ST_PULSE;
            if (count_q != {CNT_W{1'b1}}) count_d = count_q + 1'b1;
          end
        end
        ST_PULSE: begin
          state_d = ST_GAP;
          gap_d   = 8'(GAP_CYCLES);
        end
        ST_GAP: begin
          gap_d = gap_q - 8'd1;
          if (gap_q == 8'd1) state_d = ST_IDLE;
        end
        default: state_d = ST_IDLE;
      endcase
    end

    busy_d = (state_d == ST_PULSE) || (state_d == ST_GAP);
    over_d = (state_d == ST_DONE);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= ST_IDLE;
      sync1_q      <= '0;
      sync2_q      <= '0;
      level_prev_q <= '0;
      mask_q       <= '0;
      dir_q        <= '0;
      gap_q        <= '0;
      count_q      <= '0;
      v_q          <= 1'b0;
      busy_q       <= 1'b0;
      over_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      sync1_q      <= sync1_d;
      sync2_q      <= sync2_d;
      level_prev_q <= level_prev_d;
      mask_q       <= mask_d;
      dir_q        <= dir_d;
      gap_q        <= gap_d;
      count_q      <= count_d;
      v_q          <= v_d;
      busy_q       <= busy_d;
      over_q       <= over_d;
    end
  end

  assign {n, s, e, w} = dir_q;
  assign v            = v_q;
  assign busy         = busy_q;
  assign game_over    = over_q;
  assign move_count   = count_q;

endmodule
`default_nettype wire

// File: tb/tb_room_driver.sv
`default_nettype none
// tb_room_driver: table vectors, corner sequences and random stimulus checked
// every cycle against a timeline model of button levels, pending moves and windows.
module tb_room_driver;
  localparam int DC   = 4;
  localparam int GAP  = 3;
  localparam int CW   = 8;
  localparam int CMAX = (1 << CW) - 1;
`ifdef ROOM_DRIVER_DEBOUNCE_EN
  localparam bit DEB = 1'b1;
`else
  localparam bit DEB = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic btn_n = 1'b0, btn_s = 1'b0, btn_e = 1'b0, btn_w = 1'b0;
  logic room_sw = 1'b0, room_win = 1'b0, room_d = 1'b0;
  logic n, s, e, w, v, busy, game_over;
  logic [CW-1:0] move_count;

  room_driver #(.DEBOUNCE_CYCLES(DC), .GAP_CYCLES(GAP), .CNT_W(CW)) dut (
    .clk(clk), .reset_n(reset_n),
    .btn_n(btn_n), .btn_s(btn_s), .btn_e(btn_e), .btn_w(btn_w),
    .room_sw(room_sw), .room_win(room_win), .room_d(room_d),
    .n(n), .s(s), .e(e), .w(w), .v(v), .busy(busy), .game_over(game_over),
    .move_count(move_count)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Model: per-cycle raw button history and the resulting accepted levels.
  logic [3:0] bh[$];
  logic [3:0] lv[$];
  logic [3:0] m_pend, m_dir;
  int         m_ready, m_cnt;
  bit         m_done, m_v, m_busy;

  int         n_pulses, cyc, first_t, second_t;
  logic [3:0] first_dir;

  typedef struct {
    logic [3:0] btn;
    int         hold;
    int         exp_n;
    logic [3:0] exp_first;
    int         exp_space;
  } vec_t;
  vec_t tbl[5];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [3:0] bat(input int i);
    if (i < 0) return 4'b0;
    return bh[i];
  endfunction

  function automatic logic [3:0] lat(input int i);
    if (i < 0) return 4'b0;
    return lv[i];
  endfunction

  task automatic model_reset();
    bh.delete();
    lv.delete();
    m_pend = '0; m_dir = '0; m_ready = 0; m_cnt = 0;
    m_done = 1'b0; m_v = 1'b0; m_busy = 1'b0;
  endtask

  // Expected outputs after the clock edge that samples these inputs.
  task automatic model_step(input logic [3:0] b, input bit sw, input bit win, input bit d);
    int k;
    logic [3:0] prev, nl, edge_v, sel, t;
    bit stable;
    bh.push_back(b);
    k = bh.size() - 1;
    prev = lat(k - 1);
    if (DEB) begin
      nl = prev;
      for (int i = 0; i < 4; i++) begin
        stable = 1'b1;
        for (int j = 0; j < DC; j++) begin
          t = bat(k - 2 - j);
          if (t[i] == prev[i]) stable = 1'b0;
        end
        if (stable) nl[i] = ~prev[i];
      end
    end else begin
      nl = bat(k - 1);
    end
    edge_v = lat(k - 1) & ~lat(k - 2);
    lv.push_back(nl);

    m_v   = m_v | sw;
    m_dir = '0;
    if (m_done || win || d) begin
      m_done = 1'b1;
      m_pend = '0;
    end else begin
      if (m_pend != 0 && k >= m_ready) begin
        sel = 4'b1000;
        while ((m_pend & sel) == 0) sel = sel >> 1;
        m_dir   = sel;
        m_pend  = m_pend & ~sel;
        if (m_cnt < CMAX) m_cnt++;
        m_ready = k + GAP + 2;
      end
      m_pend = m_pend | edge_v;
    end
    m_busy = !m_done && (k <= m_ready - 2);
  endtask

  task automatic cycle(input logic [3:0] b, input bit sw = 1'b0, input bit win = 1'b0, input bit d = 1'b0);
    {btn_n, btn_s, btn_e, btn_w} = b;
    room_sw = sw; room_win = win; room_d = d;
    model_step(b, sw, win, d);
    @(posedge clk);
    @(negedge clk);
    cyc++;
    check("outputs{nsew,v,busy,over}", {25'd0, n, s, e, w, v, busy, game_over},
          {25'd0, m_dir, m_v, m_busy, m_done});
    check("move_count", {24'd0, move_count}, m_cnt);
    if ({n, s, e, w} != 4'b0) begin
      n_pulses++;
      if (n_pulses == 1) begin first_dir = {n, s, e, w}; first_t = cyc; end
      else if (n_pulses == 2) second_t = cyc;
    end
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    {btn_n, btn_s, btn_e, btn_w} = 4'b0;
    room_sw = 1'b0; room_win = 1'b0; room_d = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("reset_state", {17'd0, n, s, e, w, v, busy, game_over, move_count}, 32'd0);
    reset_n = 1'b1;
    model_reset();
    n_pulses = 0; cyc = 0; first_t = 0; second_t = 0; first_dir = '0;
  endtask

  initial begin
    int p;
    logic [3:0] cur;

    tbl[0] = '{4'b0010, 20, 1, 4'b0010, 0};
    tbl[1] = '{4'b1001,  8, 2, 4'b1000, GAP + 2};
    tbl[2] = '{4'b0100,  2, DEB ? 0 : 1, DEB ? 4'b0000 : 4'b0100, 0};
    tbl[3] = '{4'b1111,  8, 4, 4'b1000, GAP + 2};
    tbl[4] = '{4'b0110,  6, 2, 4'b0100, GAP + 2};

    for (int r = 0; r < 5; r++) begin
      do_reset();
      repeat (tbl[r].hold) cycle(tbl[r].btn);
      repeat (40) cycle(4'b0);
      check("tbl_pulse_count", n_pulses, tbl[r].exp_n);
      check("tbl_first_dir", {28'd0, first_dir}, {28'd0, tbl[r].exp_first});
      check("tbl_spacing", (n_pulses >= 2) ? (second_t - first_t) : 0, tbl[r].exp_space);
      check("tbl_move_count", {24'd0, move_count}, tbl[r].exp_n);
    end

    // Sticky sword flag, then asynchronous clear.
    do_reset();
    cycle(4'b0, 1'b1);
    repeat (100) cycle(4'b0);
    reset_n = 1'b0;
    #1;
    check("v_async_clear", {31'd0, v}, 32'd0);

    // Death with two moves still pending.
    do_reset();
    repeat (8) cycle(4'b1110);
    for (int i = 0; i < 30; i++) begin
      if (n_pulses > 0) break;
      cycle(4'b0);
    end
    check("death_first_pulse_seen", n_pulses, 1);
    cycle(4'b0, 1'b0, 1'b0, 1'b1);
    check("death_game_over", {31'd0, game_over}, 32'd1);
    p = n_pulses;
    repeat (10) cycle(4'b1111);
    repeat (10) cycle(4'b0);
    repeat (10) cycle(4'b0001);
    repeat (10) cycle(4'b0);
    check("death_no_more_pulses", n_pulses, p);
    check("death_move_count", {24'd0, move_count}, 32'd1);

    // Reset while a pulse is on the outputs.
    do_reset();
    repeat (6) cycle(4'b0010);
    for (int i = 0; i < 30; i++) begin
      if (n_pulses > 0) break;
      cycle(4'b0);
    end
    check("midpulse_seen", n_pulses, 1);
    reset_n = 1'b0;
    #1;
    check("midpulse_async_reset", {18'd0, n, s, e, w, busy, game_over, move_count}, 32'd0);

    // 260 separate presses: counter must stop at its maximum.
    do_reset();
    for (int i = 0; i < 260; i++) begin
      repeat (5) cycle(4'b1000 >> (i % 4));
      repeat (5) cycle(4'b0);
    end
    repeat (10) cycle(4'b0);
    check("saturate", {24'd0, move_count}, CMAX);

    // Random button activity, occasional sword/win/death.
    for (int run = 0; run < 2; run++) begin
      do_reset();
      cur = '0;
      for (int i = 0; i < 500; i++) begin
        if ($urandom_range(0, 3) == 0) cur = 4'($urandom_range(0, 15));
        cycle(cur, $urandom_range(0, 49) == 0, $urandom_range(0, 599) == 0,
              $urandom_range(0, 599) == 0);
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
